// File: rtl/sram_bist_seq_pkg.sv
// rtl/sram_bist_seq_pkg.sv - shared state encoding and default sizing for the SRAM BIST sequencer
package sram_bist_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RECORD    = 3'd4,
        S_GAP       = 3'd5
    } seq_state_t;

    // 20 ms at 50 MHz for the button, ~12 ms watchdog per run
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 600000;
    localparam int DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/push_button_debounce.sv
// rtl/push_button_debounce.sv - 2-flop synchroniser, stable-level debouncer and rising-edge pulse for a board button
module push_button_debounce
    import sram_bist_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic pulse
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

    logic          sync_0;
    logic          sync_1;
    logic          level;
    logic [CW-1:0] count;

    // The counter only runs while the synchronised input disagrees with the accepted level,
    // so any bounce back to the old level restarts the qualification window.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
            level  <= 1'b0;
            count  <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_0 <= button;
            sync_1 <= sync_0;
            pulse  <= 1'b0;
            if (sync_1 == level) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                level <= sync_1;
                count <= '0;
                pulse <= sync_1;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_bist_sequencer.sv
// rtl/sram_bist_sequencer.sv - BIST engine launcher with pass/fail bookkeeping; SRAM_BIST_SEQ_TIMEOUT_EN adds a per-run watchdog
module sram_bist_sequencer
    import sram_bist_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start_button,
    input  logic             Loop_enable,
    output logic             BIST_start,
    input  logic             BIST_finish,
    input  logic             BIST_mismatch,
    output logic             Busy,
    output logic             Last_pass,
    output logic [CNT_W-1:0] Pass_count,
    output logic [CNT_W-1:0] Fail_count,
    output logic [31:0]      Last_cycles
`ifdef SRAM_BIST_SEQ_TIMEOUT_EN
    ,
    output logic             Timeout
`endif
);

    seq_state_t  state;
    seq_state_t  next_state;
    logic        req;
    logic        start_next;
    logic        busy_next;
    logic        watchdog_hit;
    logic        mismatch_seen;
    logic [31:0] cycle_count;

    push_button_debounce #(
        .STABLE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (Clock),
        .reset (Reset),
        .button(Start_button),
        .pulse (req)
    );

`ifdef SRAM_BIST_SEQ_TIMEOUT_EN
    logic [31:0] watchdog;

    assign watchdog_hit = ((state == S_WAIT_ACK) || (state == S_WAIT_DONE)) &&
                          (watchdog == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            watchdog <= '0;
            Timeout  <= 1'b0;
        end else begin
            if ((state == S_WAIT_ACK) || (state == S_WAIT_DONE)) begin
                watchdog <= watchdog + 32'd1;
            end else begin
                watchdog <= '0;
            end
            if (watchdog_hit) begin
                Timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign watchdog_hit       = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            BIST_start <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= next_state;
            BIST_start <= start_next;
            Busy       <= busy_next;
        end
    end

    // Outputs are decoded from next_state and registered so the engine sees a glitch-free start level.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:      if (req) next_state = S_START;
            S_START:     next_state = S_WAIT_ACK;
            S_WAIT_ACK:  if (!BIST_finish) next_state = S_WAIT_DONE;
            S_WAIT_DONE: if (BIST_finish) next_state = S_RECORD;
            S_RECORD:    next_state = Loop_enable ? S_GAP : S_IDLE;
            S_GAP:       next_state = S_START;
            default:     next_state = S_IDLE;
        endcase
        if (watchdog_hit) begin
            next_state = S_IDLE;
        end
        start_next = (next_state == S_START) || (next_state == S_WAIT_ACK);
        busy_next  = (next_state != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cycle_count   <= '0;
            mismatch_seen <= 1'b0;
            Last_pass     <= 1'b0;
            Pass_count    <= '0;
            Fail_count    <= '0;
            Last_cycles   <= '0;
        end else begin
            case (state)
                S_IDLE, S_GAP: cycle_count <= '0;
                S_START, S_WAIT_ACK, S_WAIT_DONE: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                default: ;
            endcase

            if ((state == S_WAIT_DONE) && BIST_finish) begin
                mismatch_seen <= BIST_mismatch;
            end

            if (state == S_RECORD) begin
                Last_pass   <= ~mismatch_seen;
                Last_cycles <= cycle_count;
                if (mismatch_seen) begin
                    if (Fail_count != '1) Fail_count <= Fail_count + CNT_W'(1);
                end else begin
                    if (Pass_count != '1) Pass_count <= Pass_count + CNT_W'(1);
                end
            end

            // A watchdog expiry is booked as a failed run; cycle length is left untouched.
            if (watchdog_hit) begin
                Last_pass <= 1'b0;
                if (Fail_count != '1) Fail_count <= Fail_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_bist_sequencer.sv
// tb/tb_sram_bist_sequencer.sv - self-checking bench for sram_bist_sequencer with a behavioural BIST engine
module tb_sram_bist_sequencer;

    localparam int DEB     = 100;
    localparam int TO      = 50;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          Clock         = 1'b0;
    logic          Reset         = 1'b1;
    logic          Start_button  = 1'b0;
    logic          Loop_enable   = 1'b0;
    logic          BIST_finish   = 1'b1;
    logic          BIST_mismatch = 1'b0;
    wire           BIST_start;
    wire           Busy;
    wire           Last_pass;
    wire [CW-1:0]  Pass_count;
    wire [CW-1:0]  Fail_count;
    wire [31:0]    Last_cycles;
`ifdef SRAM_BIST_SEQ_TIMEOUT_EN
    wire           Timeout;
`endif

    sram_bist_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start_button (Start_button),
        .Loop_enable  (Loop_enable),
        .BIST_start   (BIST_start),
        .BIST_finish  (BIST_finish),
        .BIST_mismatch(BIST_mismatch),
        .Busy         (Busy),
        .Last_pass    (Last_pass),
        .Pass_count   (Pass_count),
        .Fail_count   (Fail_count),
        .Last_cycles  (Last_cycles)
`ifdef SRAM_BIST_SEQ_TIMEOUT_EN
        ,
        .Timeout      (Timeout)
`endif
    );

    always #10 Clock = ~Clock;

    // Behavioural engine: a run starts on a sampled 0->1 of BIST_start, lasts len cycles,
    // and reports a mismatch if the SRAM model has a stuck bit at 18'h20005.
    logic [17:0] stuck_addr     = 18'h20005;
    bit          stuck_en       = 1'b0;
    bit          eng_hang       = 1'b0;
    bit          rand_len       = 1'b0;
    int          fixed_len      = 10;
    logic        eng_prev_start = 1'b0;
    int          eng_remain     = 0;

    always @(posedge Clock) begin
        eng_prev_start <= BIST_start;
        if (BIST_start && !eng_prev_start && BIST_finish) begin
            BIST_finish   <= 1'b0;
            BIST_mismatch <= 1'b0;
            eng_remain    <= rand_len ? int'($urandom_range(20, 3)) : fixed_len;
        end else if (!BIST_finish && !eng_hang) begin
            if (eng_remain == 0) begin
                BIST_finish   <= 1'b1;
                BIST_mismatch <= stuck_en && (stuck_addr == 18'h20005);
            end else begin
                eng_remain <= eng_remain - 1;
            end
        end
    end

    // Observer: counts start rises, low time before each rise, and start-to-finish span.
    int   starts    = 0;
    int   low_len   = 0;
    int   gaps[int];
    int   span      = 0;
    int   last_span = 0;
    bit   measuring = 1'b0;
    bit   saw_low   = 1'b0;
    logic mon_prev  = 1'b0;

    always @(negedge Clock) begin
        if (BIST_start && !mon_prev) begin
            gaps[starts] = low_len;
            starts       = starts + 1;
            measuring    = 1'b1;
            saw_low      = 1'b0;
            span         = 0;
        end
        if (BIST_start) low_len = 0;
        else            low_len = low_len + 1;
        if (measuring) begin
            span = span + 1;
            if (!BIST_finish) saw_low = 1'b1;
            else if (saw_low) begin
                last_span = span;
                measuring = 1'b0;
            end
        end
        mon_prev = BIST_start;
    end

    int total = 0;
    int bad   = 0;
    int exp_pass = 0;
    int exp_fail = 0;
    bit exp_last = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic book(input int n, input bit failed);
        for (int i = 0; i < n; i++) begin
            if (failed) exp_fail = sat(exp_fail + 1);
            else        exp_pass = sat(exp_pass + 1);
        end
        exp_last = !failed;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic press(input int hold);
        Start_button = 1'b1;
        cycles(hold);
        Start_button = 1'b0;
        cycles(DEB + 12);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (Busy !== 1'b0 && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_idle_timeout"}, 64'(n >= 3000), 0);
        cycles(2);
    endtask

    task automatic wait_starts(input string tag, input int target);
        int n = 0;
        while (starts < target && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_start_timeout"}, 64'(n >= 3000), 0);
    endtask

    task automatic check_books(input string tag);
        check({tag, "_pass_count"}, Pass_count, exp_pass);
        check({tag, "_fail_count"}, Fail_count, exp_fail);
        check({tag, "_last_pass"}, Last_pass, exp_last);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_last_cycles"}, Last_cycles, last_span);
    endtask

    // Holds the button until `runs` loop runs have started, then clears Loop_enable.
    task automatic loop_runs(input string tag, input int runs, input bit failed);
        int s0 = starts;
        stuck_en     = failed;
        rand_len     = 1'b1;
        Loop_enable  = 1'b1;
        Start_button = 1'b1;
        wait_starts(tag, s0 + runs);
        Loop_enable  = 1'b0;
        wait_idle(tag);
        Start_button = 1'b0;
        cycles(DEB + 12);
        book(runs, failed);
        check({tag, "_starts"}, starts - s0, runs);
        for (int k = 1; k < runs; k++) begin
            check({tag, "_gap_ge3"}, 64'(gaps[s0 + k] >= 3), 1);
        end
        check_books(tag);
        stuck_en = 1'b0;
        rand_len = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int s0;
        int n;

        cycles(5);
        check("rst_bist_start", BIST_start, 0);
        check("rst_busy", Busy, 0);
        check("rst_last_pass", Last_pass, 0);
        check("rst_pass_count", Pass_count, 0);
        check("rst_fail_count", Fail_count, 0);
        check("rst_last_cycles", Last_cycles, 0);
        Reset = 1'b0;
        cycles(5);

        fixed_len = int'($urandom_range(25, 5));
        s0 = starts;
        press(150);
        wait_idle("single");
        book(1, 1'b0);
        check("single_starts", starts - s0, 1);
        check_books("single");
        check("single_span", Last_cycles, fixed_len + 3);

        fixed_len = int'($urandom_range(25, 5));
        stuck_en = 1'b1;
        s0 = starts;
        press(150);
        wait_idle("stuck");
        book(1, 1'b1);
        check("stuck_starts", starts - s0, 1);
        check_books("stuck");
        check("stuck_span", Last_cycles, fixed_len + 3);
        stuck_en = 1'b0;

        s0 = starts;
        repeat (5) begin
            Start_button = 1'b1;
            cycles(10);
            Start_button = 1'b0;
            cycles(10);
        end
        cycles(DEB + 30);
        check("bounce_no_start", starts - s0, 0);
        check("bounce_busy", Busy, 0);
        press(150);
        wait_idle("bounce_hold");
        book(1, 1'b0);
        check("bounce_hold_starts", starts - s0, 1);
        check_books("bounce_hold");

        fixed_len = 400;
        s0 = starts;
        press(150);
        press(150);
        wait_idle("busy_press");
        book(1, 1'b0);
        check("busy_press_starts", starts - s0, 1);
        check_books("busy_press");

        loop_runs("loop3", 3, 1'b0);
        loop_runs("pass_sat", 5, 1'b0);
        loop_runs("fail_sat", 7, 1'b1);

        fixed_len = 300;
        Start_button = 1'b1;
        n = 0;
        while (Busy !== 1'b1 && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        check("midrun_busy_timeout", 64'(n >= 1000), 0);
        Start_button = 1'b0;
        cycles(5);
        Reset = 1'b1;
        cycles(1);
        check("midrun_rst_bist_start", BIST_start, 0);
        check("midrun_rst_busy", Busy, 0);
        check("midrun_rst_pass", Pass_count, 0);
        check("midrun_rst_fail", Fail_count, 0);
        check("midrun_rst_cycles", Last_cycles, 0);
        Reset = 1'b0;
        cycles(DEB + 20);
        check("midrun_no_restart", Busy, 0);

`ifdef SRAM_BIST_SEQ_TIMEOUT_EN
        eng_hang = 1'b1;
        Start_button = 1'b1;
        n = 0;
        while (Busy !== 1'b1 && n < 1000) begin
            @(negedge Clock);
            n++;
        end
        check("to_busy_timeout", 64'(n >= 1000), 0);
        Start_button = 1'b0;
        cycles(TO - 10);
        check("to_not_yet", Timeout, 0);
        cycles(20);
        check("to_flag", Timeout, 1);
        check("to_fail_count", Fail_count, 1);
        check("to_pass_count", Pass_count, 0);
        check("to_last_pass", Last_pass, 0);
        check("to_busy", Busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
